// File: rtl/trap_controller.sv
// Trap sequencer: picks the oldest pending exception, flushes and drains the pipeline,
// commits the cause to the privileged registers and redirects fetch to the trap vector.
module trap_controller #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h2000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_f_exc_valid,
  input  logic [2:0]  in_f_exc_cause,
  input  logic [31:0] in_f_pc,
  input  logic [31:0] in_f_addr,
  input  logic        in_d_exc_valid,
  input  logic [2:0]  in_d_exc_cause,
  input  logic [31:0] in_d_pc,
  input  logic [31:0] in_d_info,
  input  logic        in_m_exc_valid,
  input  logic [2:0]  in_m_exc_cause,
  input  logic [31:0] in_m_pc,
  input  logic [31:0] in_m_addr,
  input  logic        in_iret_valid,
  input  logic        in_supervisor_mode,
  input  logic        in_mem_busy,
  output logic [2:0]  out_exception_vector,
  output logic [31:0] out_fault_pc,
  output logic [31:0] out_fault_addr,
  output logic [31:0] out_additional_info,
  output logic        out_flush_f,
  output logic        out_flush_d,
  output logic        out_flush_x,
  output logic        out_flush_m,
  output logic        out_stall,
  output logic        out_redirect,
  output logic [31:0] out_redirect_pc,
  output logic        out_double_fault,
  output logic [15:0] out_trap_count
);

  typedef enum logic [2:0] {StIdle, StDrain, StCommit, StRedirect, StIretFlush, StHalt} state_e;

  localparam logic [3:0] FlushCnt = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, info_q, info_d;
  logic [31:0] fault_pc_q, fault_pc_d, fault_addr_q, fault_addr_d, fault_info_q, fault_info_d;
  logic [3:0]  flush_q, flush_d;  // {m, x, d, f}
  logic [3:0]  cnt_q, cnt_d;
  logic        dbl_q, dbl_d;
  logic [15:0] trap_cnt_q, trap_cnt_d;

  logic m_ok, d_ok, f_ok;
  assign m_ok = in_m_exc_valid && (in_m_exc_cause != 3'd0);
  assign d_ok = in_d_exc_valid && (in_d_exc_cause != 3'd0);
  assign f_ok = in_f_exc_valid && (in_f_exc_cause != 3'd0);

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    info_d       = info_q;
    fault_pc_d   = fault_pc_q;
    fault_addr_d = fault_addr_q;
    fault_info_d = fault_info_q;
    flush_d      = 4'b0000;
    cnt_d        = cnt_q;
    dbl_d        = dbl_q;
    trap_cnt_d   = trap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m_ok || d_ok || f_ok) begin
          if (in_supervisor_mode) begin
            state_d = StHalt;
            dbl_d   = 1'b1;
            flush_d = 4'b1111;
          end else begin
            state_d = StDrain;
            cnt_d   = 4'd1;
            if (m_ok) begin
              cause_d = in_m_exc_cause;
              pc_d    = in_m_pc;
              addr_d  = in_m_addr;
              info_d  = 32'd0;
              flush_d = 4'b1111;
            end else if (d_ok) begin
              cause_d = in_d_exc_cause;
              pc_d    = in_d_pc;
              addr_d  = 32'd0;
              info_d  = in_d_info;
              flush_d = 4'b0011;
            end else begin
              cause_d = in_f_exc_cause;
              pc_d    = in_f_pc;
              addr_d  = in_f_addr;
              info_d  = 32'd0;
              flush_d = 4'b0001;
            end
          end
        end else if (in_iret_valid) begin
          state_d = StIretFlush;
          flush_d = 4'b0011;
        end
      end
      StDrain: begin
        if ((cnt_q >= FlushCnt) && !in_mem_busy) begin
          state_d      = StCommit;
          fault_pc_d   = pc_q;
          fault_addr_d = addr_q;
          fault_info_d = info_q;
          if (trap_cnt_q != 16'hFFFF) trap_cnt_d = trap_cnt_q + 16'd1;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCommit:    state_d = StRedirect;
      StRedirect:  state_d = StIdle;
      StIretFlush: state_d = StIdle;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cause_q      <= 3'd0;
      pc_q         <= 32'd0;
      addr_q       <= 32'd0;
      info_q       <= 32'd0;
      fault_pc_q   <= 32'd0;
      fault_addr_q <= 32'd0;
      fault_info_q <= 32'd0;
      flush_q      <= 4'b0000;
      cnt_q        <= 4'd0;
      dbl_q        <= 1'b0;
      trap_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      info_q       <= info_d;
      fault_pc_q   <= fault_pc_d;
      fault_addr_q <= fault_addr_d;
      fault_info_q <= fault_info_d;
      flush_q      <= flush_d;
      cnt_q        <= cnt_d;
      dbl_q        <= dbl_d;
      trap_cnt_q   <= trap_cnt_d;
    end
  end

  assign out_exception_vector = (state_q == StCommit) ? cause_q : 3'd0;
  assign out_fault_pc         = fault_pc_q;
  assign out_fault_addr       = fault_addr_q;
  assign out_additional_info  = fault_info_q;
  assign out_flush_f          = flush_q[0];
  assign out_flush_d          = flush_q[1];
  assign out_flush_x          = flush_q[2];
  assign out_flush_m          = flush_q[3];
  assign out_stall            = (state_q != StIdle);
  assign out_redirect         = (state_q == StRedirect);
  assign out_redirect_pc      = (state_q == StRedirect) ? TRAP_VECTOR : 32'd0;
  assign out_double_fault     = dbl_q;
  assign out_trap_count       = trap_cnt_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed vector bench for trap_controller: table of exception/iret cases plus
// hand sequences for double fault, reset during drain and count saturation.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_f_exc_valid, in_d_exc_valid, in_m_exc_valid;
  logic [2:0]  in_f_exc_cause, in_d_exc_cause, in_m_exc_cause;
  logic [31:0] in_f_pc, in_f_addr, in_d_pc, in_d_info, in_m_pc, in_m_addr;
  logic        in_iret_valid, in_supervisor_mode, in_mem_busy;
  logic [2:0]  out_exception_vector;
  logic [31:0] out_fault_pc, out_fault_addr, out_additional_info, out_redirect_pc;
  logic        out_flush_f, out_flush_d, out_flush_x, out_flush_m;
  logic        out_stall, out_redirect, out_double_fault;
  logic [15:0] out_trap_count;

  trap_controller #(.TRAP_VECTOR(32'h2000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .in_f_exc_valid(in_f_exc_valid), .in_f_exc_cause(in_f_exc_cause),
    .in_f_pc(in_f_pc), .in_f_addr(in_f_addr),
    .in_d_exc_valid(in_d_exc_valid), .in_d_exc_cause(in_d_exc_cause),
    .in_d_pc(in_d_pc), .in_d_info(in_d_info),
    .in_m_exc_valid(in_m_exc_valid), .in_m_exc_cause(in_m_exc_cause),
    .in_m_pc(in_m_pc), .in_m_addr(in_m_addr),
    .in_iret_valid(in_iret_valid), .in_supervisor_mode(in_supervisor_mode),
    .in_mem_busy(in_mem_busy),
    .out_exception_vector(out_exception_vector), .out_fault_pc(out_fault_pc),
    .out_fault_addr(out_fault_addr), .out_additional_info(out_additional_info),
    .out_flush_f(out_flush_f), .out_flush_d(out_flush_d),
    .out_flush_x(out_flush_x), .out_flush_m(out_flush_m),
    .out_stall(out_stall), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_double_fault(out_double_fault),
    .out_trap_count(out_trap_count)
  );

  always #5 clk = ~clk;

  // kind: 0 = exception, 1 = iret flush, 2 = nothing happens
  typedef struct {
    int          kind;
    logic        f_v; logic [2:0] f_c; logic [31:0] f_pc; logic [31:0] f_addr;
    logic        d_v; logic [2:0] d_c; logic [31:0] d_pc; logic [31:0] d_info;
    logic        m_v; logic [2:0] m_c; logic [31:0] m_pc; logic [31:0] m_addr;
    logic        iret;
    int          busy;
    logic [3:0]  e_mask; logic [2:0] e_vec;
    logic [31:0] e_pc; logic [31:0] e_addr; logic [31:0] e_info;
    int          e_commit;
  } vec_t;

  vec_t        vt[10];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] last_pc = 0, last_addr = 0, last_info = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flushes();
    return {28'd0, out_flush_m, out_flush_x, out_flush_d, out_flush_f};
  endfunction

  task automatic clear_req();
    in_f_exc_valid = 0; in_f_exc_cause = 0; in_f_pc = 0; in_f_addr = 0;
    in_d_exc_valid = 0; in_d_exc_cause = 0; in_d_pc = 0; in_d_info = 0;
    in_m_exc_valid = 0; in_m_exc_cause = 0; in_m_pc = 0; in_m_addr = 0;
    in_iret_valid = 0; in_supervisor_mode = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stall"}, 32'(out_stall), 0);
    check({tag, " flush"}, flushes(), 0);
    check({tag, " vector"}, 32'(out_exception_vector), 0);
    check({tag, " fault_pc"}, out_fault_pc, 0);
    check({tag, " fault_addr"}, out_fault_addr, 0);
    check({tag, " info"}, out_additional_info, 0);
    check({tag, " redirect"}, 32'(out_redirect), 0);
    check({tag, " redirect_pc"}, out_redirect_pc, 0);
    check({tag, " double_fault"}, 32'(out_double_fault), 0);
    check({tag, " trap_count"}, 32'(out_trap_count), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    last;
    string t;
    t = $sformatf("vec%0d", idx);
    in_f_exc_valid = v.f_v; in_f_exc_cause = v.f_c; in_f_pc = v.f_pc; in_f_addr = v.f_addr;
    in_d_exc_valid = v.d_v; in_d_exc_cause = v.d_c; in_d_pc = v.d_pc; in_d_info = v.d_info;
    in_m_exc_valid = v.m_v; in_m_exc_cause = v.m_c; in_m_pc = v.m_pc; in_m_addr = v.m_addr;
    in_iret_valid = v.iret; in_supervisor_mode = 0;
    in_mem_busy = (v.busy > 0);
    last = (v.kind == 0) ? v.e_commit + 2 : (v.kind == 1) ? 2 : 1;
    for (int c = 1; c <= last; c++) begin
      step();
      clear_req();
      in_mem_busy = (c < v.busy);
      if (v.kind == 0) begin
        if (c == 1) check({t, " flush pulse"}, flushes(), 32'(v.e_mask));
        else check({t, " flush idle"}, flushes(), 0);
        if (c == v.e_commit) begin
          check({t, " commit vector"}, 32'(out_exception_vector), 32'(v.e_vec));
          check({t, " fault_pc"}, out_fault_pc, v.e_pc);
          check({t, " fault_addr"}, out_fault_addr, v.e_addr);
          check({t, " info"}, out_additional_info, v.e_info);
          last_pc = v.e_pc; last_addr = v.e_addr; last_info = v.e_info;
        end else begin
          check({t, " vector quiet"}, 32'(out_exception_vector), 0);
        end
        if (c == v.e_commit + 1) begin
          if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
          check({t, " redirect"}, 32'(out_redirect), 1);
          check({t, " redirect_pc"}, out_redirect_pc, 32'h2000);
          check({t, " trap_count"}, 32'(out_trap_count), 32'(exp_count));
        end else begin
          check({t, " redirect quiet"}, 32'(out_redirect), 0);
        end
        check({t, " stall"}, 32'(out_stall), (c <= v.e_commit + 1) ? 1 : 0);
        if (c == last) check({t, " fault_pc hold"}, out_fault_pc, v.e_pc);
      end else begin
        check({t, " flush"}, flushes(), (v.kind == 1 && c == 1) ? 32'h3 : 0);
        check({t, " stall"}, 32'(out_stall), (v.kind == 1 && c == 1) ? 1 : 0);
        check({t, " vector"}, 32'(out_exception_vector), 0);
        check({t, " redirect"}, 32'(out_redirect), 0);
        check({t, " fault_pc hold"}, out_fault_pc, last_pc);
        check({t, " trap_count"}, 32'(out_trap_count), 32'(exp_count));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        kind f_v f_c pc addr | d_v d_c pc info | m_v m_c pc addr | iret busy | mask vec pc addr info commit
    vt[0] = '{0, 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 1, 3'd2, 32'h104, 32'hDEAD0000,
              0, 0, 4'hF, 3'd2, 32'h104, 32'hDEAD0000, 32'h0, 3};
    vt[1] = '{0, 1, 3'd1, 32'h10C, 32'h10C, 1, 3'd4, 32'h108, 32'hFFFFFFFF, 1, 3'd0, 32'h110,
              32'h99, 0, 0, 4'h3, 3'd4, 32'h108, 32'h0, 32'hFFFFFFFF, 3};
    vt[2] = '{0, 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 1, 3'd6, 32'h200, 32'h40,
              0, 5, 4'hF, 3'd6, 32'h200, 32'h40, 32'h0, 6};
    vt[3] = '{0, 1, 3'd1, 32'h300, 32'h3000, 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0,
              1, 0, 4'h1, 3'd1, 32'h300, 32'h3000, 32'h0, 3};
    vt[4] = '{1, 1, 3'd0, 32'h1, 32'h1, 0, 3'd5, 32'h2, 32'h2, 0, 3'd7, 32'h3, 32'h3,
              1, 0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 0};
    vt[5] = '{2, 0, 3'd3, 32'h1, 32'h1, 1, 3'd0, 32'h2, 32'h2, 0, 3'd0, 32'h0, 32'h0,
              0, 0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h0, 0};
    vt[6] = '{0, 1, 3'd3, 32'h404, 32'h404, 1, 3'd7, 32'h400, 32'h12345678, 0, 3'd0, 32'h0,
              32'h0, 0, 0, 4'h3, 3'd7, 32'h400, 32'h0, 32'h12345678, 3};
    vt[7] = '{0, 1, 3'd2, 32'h508, 32'h508, 1, 3'd3, 32'h504, 32'hABCD, 1, 3'd1, 32'h500,
              32'hA0, 0, 0, 4'hF, 3'd1, 32'h500, 32'hA0, 32'h0, 3};
    vt[8] = '{0, 1, 3'd5, 32'h600, 32'h604, 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0,
              0, 2, 4'h1, 3'd5, 32'h600, 32'h604, 32'h0, 3};
    vt[9] = '{0, 1, 3'd1, 32'h800, 32'h804, 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0,
              0, 0, 4'h1, 3'd1, 32'h800, 32'h804, 32'h0, 3};

    clear_req();
    in_mem_busy = 0;
    reset = 1;
    step(); step();
    reset = 0;
    check_all_zero("reset");

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Reset in the first DRAIN cycle discards the pending trap.
    in_m_exc_valid = 1; in_m_exc_cause = 3'd2; in_m_pc = 32'h700; in_m_addr = 32'h77;
    step();
    clear_req();
    check("middrain stall", 32'(out_stall), 1);
    reset = 1;
    step();
    reset = 0;
    check_all_zero("middrain");
    exp_count = 0; last_pc = 0; last_addr = 0; last_info = 0;
    step();
    check("middrain idle", 32'(out_stall), 0);
    run_vec(vt[9], 9);

    // Count saturation: preload near the top, then two more commits.
    force dut.trap_cnt_q = 16'hFFFE;
    #1;
    release dut.trap_cnt_q;
    exp_count = 16'hFFFE;
    run_vec(vt[9], 90);
    run_vec(vt[9], 91);

    // Double fault: exception while in supervisor mode.
    in_d_exc_valid = 1; in_d_exc_cause = 3'd4; in_d_pc = 32'h900; in_d_info = 32'h55;
    in_supervisor_mode = 1;
    step();
    clear_req();
    check("halt flush", flushes(), 32'hF);
    check("halt double_fault", 32'(out_double_fault), 1);
    check("halt stall", 32'(out_stall), 1);
    check("halt vector", 32'(out_exception_vector), 0);
    in_f_exc_valid = 1; in_f_exc_cause = 3'd1; in_f_pc = 32'hA00;
    for (int c = 0; c < 20; c++) begin
      step();
      check("halt hold stall", 32'(out_stall), 1);
      check("halt hold vector", 32'(out_exception_vector), 0);
      check("halt hold flush", flushes(), 0);
      check("halt hold redirect", 32'(out_redirect), 0);
      check("halt hold double_fault", 32'(out_double_fault), 1);
    end
    check("halt trap_count", 32'(out_trap_count), 32'hFFFF);
    clear_req();
    reset = 1;
    step();
    reset = 0;
    check_all_zero("halt reset");
    step();
    check("post reset idle", 32'(out_stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Collects exception requests from the fetch, decode and memory stages and selects the oldest in program order.
- Flushes younger pipeline stages, stalls the pipeline and waits for outstanding memory traffic to drain.
- Issues a one-cycle exception commit to the privileged register file, then redirects fetch to the trap vector.
- Also sequences the pipeline flush for iret. Detects an exception raised in supervisor mode and halts with a sticky double-fault flag.

Parameters:
TRAP_VECTOR, 32'h2000, fetch redirect target after an exception commit
FLUSH_CYCLES, 2, minimum cycles spent in DRAIN (1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_f_exc_valid  input  1  fetch-stage exception request
in_f_exc_cause  input  3  fetch cause code (0 = none)
in_f_pc  input  32  PC of the faulting fetch
in_f_addr  input  32  faulting fetch address
in_d_exc_valid  input  1  decode-stage exception request (e.g. illegal instruction)
in_d_exc_cause  input  3  decode cause code
in_d_pc  input  32  PC of the decode-stage instruction
in_d_info  input  32  raw instruction word
in_m_exc_valid  input  1  memory-stage exception request
in_m_exc_cause  input  3  memory cause code
in_m_pc  input  32  PC of the memory-stage instruction
in_m_addr  input  32  faulting data address
in_iret_valid  input  1  decode has an iret (write to rm4)
in_supervisor_mode  input  1  current privilege (rm4[0])
in_mem_busy  input  1  data-memory transaction outstanding
out_exception_vector  output  3  cause to the privileged regs; nonzero for exactly one cycle
out_fault_pc  output  32  latched fault PC
out_fault_addr  output  32  latched fault address (0 for decode faults)
out_additional_info  output  32  latched info (instruction word for decode, else 0)
out_flush_f  output  1  flush the fetch stage
out_flush_d  output  1  flush the decode stage
out_flush_x  output  1  flush the execute stage
out_flush_m  output  1  flush the memory stage
out_stall  output  1  freeze the pipeline
out_redirect  output  1  fetch redirect strobe
out_redirect_pc  output  32  redirect target
out_double_fault  output  1  sticky; the core is halted
out_trap_count  output  16  committed exceptions, saturating

Behaviour:

Validity and priority
- A request is valid only when its exc_valid is 1 and its cause is nonzero.
- Priority is M > D > F.
- Requests are sampled only in IDLE and are ignored in every other state.

States: IDLE, DRAIN, COMMIT, REDIRECT, IRET_FLUSH, HALT.

IDLE
- Valid request with in_supervisor_mode=0:
  - Latch cause, pc, addr and info of the winner.
  - Go to DRAIN.
  - Registered one-cycle flush pulse in the first DRAIN cycle, covering the winner and all younger stages:
    - M winner: flush F, D, X, M.
    - D winner: flush F, D.
    - F winner: flush F.
- Valid request with in_supervisor_mode=1:
  - Go to HALT.
  - out_double_fault<=1.
  - Pulse all four flushes for one cycle. No commit.
- in_iret_valid with no valid request: go to IRET_FLUSH.
- iret in the same cycle as a valid request: the exception wins and the iret is dropped.

DRAIN
- Internal counter counts the cycles spent in DRAIN.
- Leave when count ≥ FLUSH_CYCLES and in_mem_busy=0. Go to COMMIT.

COMMIT (one cycle)
- out_exception_vector = latched cause; drive fault pc, addr and info.
- out_trap_count increments, saturating at 16'hFFFF.
- Go to REDIRECT.

REDIRECT (one cycle)
- out_redirect=1, out_redirect_pc=TRAP_VECTOR.
- Go to IDLE.

IRET_FLUSH (one cycle)
- out_flush_f=1, out_flush_d=1.
- Go to IDLE. The privileged regs supply the return PC.

HALT
- Terminal until reset. out_stall=1.

out_stall
- Combinational: 1 whenever state≠IDLE.

Timing
- Request sampled at edge T, in_mem_busy=0, FLUSH_CYCLES=2:
  - flush at T+1
  - DRAIN at T+1 and T+2
  - COMMIT at T+3
  - REDIRECT at T+4
  - IDLE at T+5; a new request can be accepted at the T+5 edge.

Outputs outside their active state
- out_exception_vector=0.
- Fault fields hold their last value.
- out_redirect=0, out_redirect_pc=0.

Reset (any state, including mid-drain)
- State=IDLE.
- All outputs 0, including out_double_fault and out_trap_count.
- Latched record cleared.

Test Plan:
1. M cause 3'b010, pc 0x104, addr 0xDEAD0000; user mode; mem_busy=0 -> flush F/D/X/M pulse at T+1; vector 2, fault_pc 0x104, fault_addr 0xDEAD0000 at T+3; redirect to 0x2000 at T+4; trap_count=1.
2. Simultaneous F (cause 1, pc 0x10C), D (cause 4, pc 0x108, info 0xFFFFFFFF) and M (cause 0) -> D wins; flush F and D only; commit vector 4, pc 0x108, info 0xFFFFFFFF, addr 0.
3. M fault with in_mem_busy held for 5 cycles after T -> COMMIT at T+6 (not T+3); out_stall high from T+1 through T+7.
4. in_iret_valid alone -> one-cycle flush F/D and one stall cycle; no vector, no redirect. iret together with F cause 1 -> exception sequence only.
5. D cause 4 with in_supervisor_mode=1 -> HALT; double_fault=1; stall stays high for 20 cycles; no vector pulse; reset clears everything.
6. Reset asserted during DRAIN -> next cycle all outputs 0; a fresh F cause 1 is then accepted normally. Force trap_count to 0xFFFF via repeated traps -> it stays 0xFFFF after the next commit.
